mpram_arbiter: RTL

MPRAM_ARBITER -- requirements
Module: mpram_arbiter

---
 rtl/mpram_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/mpram_arbiter.sv
// Multi-port single-RAM arbiter: N clients share one word-wide memory,
// arbitrated round-robin (MODE 0) or by fixed time slots (MODE 1).
module mpram_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MODE       = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata,
  output logic [NUM_PORTS-1:0]             gnt,
  output logic [NUM_PORTS-1:0]             rvalid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rdata
);

  localparam int PW    = $clog2(NUM_PORTS);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);

  logic [PW-1:0]                   r_ptr;
  logic [PW-1:0]                   r_slot;
  logic [NUM_PORTS-1:0]            r_rvalid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0]           r_mem [DEPTH];

  logic [NUM_PORTS-1:0]  w_gnt;
  logic                  w_any;
  logic [PW-1:0]         w_sel;
  logic [PW-1:0]         w_idx;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [PW-1:0]         w_ptr_nxt;
  logic [PW-1:0]         w_slot_nxt;
  int                    v_off;

  // Descending scan so the requester closest to the pointer wins last.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
    v_off = 0;
    if (MODE == 1) begin
      w_sel = r_slot;
      w_any = req[r_slot];
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        v_off = int'(r_ptr) + k;
        if (v_off >= NUM_PORTS) v_off = v_off - NUM_PORTS;
        w_idx = PW'(v_off);
        if (req[w_idx]) begin
          w_sel = w_idx;
          w_any = 1'b1;
        end
      end
    end
    w_any = w_any & reset_n;
  end

  always_comb begin
    w_gnt        = '0;
    w_gnt[w_sel] = w_any;
  end

  assign w_we    = we[w_sel];
  assign w_addr  = addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wdata = wdata[w_sel*DATA_WIDTH +: DATA_WIDTH];

  assign w_ptr_nxt  = (w_sel == LAST) ? '0 : w_sel + 1'b1;
  assign w_slot_nxt = (r_slot == LAST) ? '0 : r_slot + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr    <= '0;
      r_slot   <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_slot   <= w_slot_nxt;
      r_rvalid <= '0;
      if (w_any) r_ptr <= w_ptr_nxt;
      if (w_any && !w_we) begin
        r_rvalid[w_sel] <= 1'b1;
        r_rdata[w_sel*DATA_WIDTH +: DATA_WIDTH] <= r_mem[w_addr];
      end
    end
  end

  // Memory has no reset; w_any is already qualified by reset_n.
  always_ff @(posedge clk) begin
    if (w_any && w_we) r_mem[w_addr] <= w_wdata;
  end

  // Outputs are masked during reset so nothing stale is visible.
  assign gnt    = w_gnt;
  assign rvalid = reset_n ? r_rvalid : '0;
  assign rdata  = reset_n ? r_rdata : '0;

endmodule
